// File: rtl/mitm_pkg.sv
// Shared encodings for the MITM rule engine: FSM states, spoof modes and
// the default Microwire/93Cxx header values for read and write frames.
package mitm_pkg;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_IDLE  = 3'd1,
        ST_HDR   = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DATA  = 3'd4,
        ST_DONE  = 3'd5
    } mitmStateT;

    // Each mode bit enables spoofing for one direction; both bits set spoofs
    // reads and writes alike.
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_READ  = 2'd1,
        MODE_WRITE = 2'd2,
        MODE_BOTH  = 2'd3
    } mitmModeT;

    localparam int MODE_READ_BIT  = 0;
    localparam int MODE_WRITE_BIT = 1;

    // Start bit followed by the two opcode bits.
    localparam logic [2:0] READ_HDR_DEFAULT  = 3'b110;
    localparam logic [2:0] WRITE_HDR_DEFAULT = 3'b101;

endpackage

// File: rtl/mitm_addr_matcher.sv
// Combinational hit decision: masked address compare, direction enable and
// the hit-limit budget all have to agree before a frame may be spoofed.
module mitm_addr_matcher #(
    parameter int ADDR_BITS = 9,
    parameter int HIT_W     = 8
) (
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [ADDR_BITS-1:0] cfgAddr_i,
    input  logic [ADDR_BITS-1:0] cfgMask_i,
    input  logic                 modeOk_i,
    input  logic [HIT_W-1:0]     hitLimit_i,
    input  logic [HIT_W-1:0]     hitCount_i,
    output logic                 hit_o
);

    logic addrMatch;
    logic underLimit;

    // A cleared mask bit makes that address bit a don't-care, so an all-zero
    // mask matches every address; a zero limit means there is no budget cap.
    always_comb begin
        addrMatch  = ((addr_i ^ cfgAddr_i) & cfgMask_i) == '0;
        underLimit = (hitLimit_i == '0) || (hitCount_i < hitLimit_i);
        hit_o      = addrMatch && modeOk_i && underLimit;
    end

endmodule

// File: rtl/mitm_rule_engine.sv
// Frame sequencer for Microwire/93Cxx MITM spoofing. Walks header, address
// and data phases on each eval pulse and, when the shadowed rule hits,
// loads MSB-aligned substitute data and raises the matching fake select.
module mitm_rule_engine
    import mitm_pkg::*;
#(
    parameter int                   MAX_DATA_SIZE   = 16,
    parameter int                   HDR_BITS        = 3,
    parameter int                   ADDR_BITS       = 9,
    parameter int                   DATA_BITS       = 8,
    parameter logic [HDR_BITS-1:0]  READ_HDR        = READ_HDR_DEFAULT,
    parameter logic [HDR_BITS-1:0]  WRITE_HDR       = WRITE_HDR_DEFAULT,
    parameter int                   HIT_W           = 8,
    parameter int                   DATA_SIZE_WIDTH = $clog2(MAX_DATA_SIZE + 1)
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic                       eval,
    input  logic                       mitm_start,
    input  logic [MAX_DATA_SIZE-1:0]   real_miso_data,
    input  logic [MAX_DATA_SIZE-1:0]   real_mosi_data,
    input  logic [1:0]                 cfg_mode,
    input  logic [ADDR_BITS-1:0]       cfg_addr,
    input  logic [ADDR_BITS-1:0]       cfg_addr_mask,
    input  logic [DATA_BITS-1:0]       cfg_data,
    input  logic [HIT_W-1:0]           cfg_hit_limit,
    output logic [MAX_DATA_SIZE-1:0]   fake_miso_data,
    output logic [MAX_DATA_SIZE-1:0]   fake_mosi_data,
    output logic [DATA_SIZE_WIDTH-1:0] data_size,
    output logic                       fake_miso_select,
    output logic                       fake_mosi_select,
    output logic [HIT_W-1:0]           hit_count,
    output logic                       eval_done,
    output logic                       mitm_done
);

    mitmStateT                  state_q, state_d;
    logic [MAX_DATA_SIZE-1:0]   fakeMiso_q, fakeMiso_d;
    logic [MAX_DATA_SIZE-1:0]   fakeMosi_q, fakeMosi_d;
    logic [DATA_SIZE_WIDTH-1:0] dataSize_q, dataSize_d;
    logic                       misoSel_q, misoSel_d;
    logic                       mosiSel_q, mosiSel_d;
    logic [HIT_W-1:0]           hitCount_q, hitCount_d;
    logic                       evalDone_q, evalDone_d;
    logic                       mitmDone_q, mitmDone_d;
    logic                       opIsWrite_q, opIsWrite_d;
    mitmModeT                   shMode_q, shMode_d;
    logic [ADDR_BITS-1:0]       shAddr_q, shAddr_d;
    logic [ADDR_BITS-1:0]       shMask_q, shMask_d;
    logic [DATA_BITS-1:0]       shData_q, shData_d;
    logic [HIT_W-1:0]           shLimit_q, shLimit_d;

    logic [HDR_BITS-1:0]        hdrBits;
    logic [ADDR_BITS-1:0]       addrBits;
    logic [MAX_DATA_SIZE-1:0]   fakeAligned;
    logic                       modeOk;
    logic                       ruleHit;
    logic                       unusedOk;

    // Only the freshly shifted low bits of MOSI carry header/address; MISO is
    // sniffed for completeness but never influences the rule decision.
    always_comb begin
        hdrBits     = real_mosi_data[HDR_BITS-1:0];
        addrBits    = real_mosi_data[ADDR_BITS-1:0];
        fakeAligned = MAX_DATA_SIZE'(shData_q) << (MAX_DATA_SIZE - DATA_BITS);
        modeOk      = opIsWrite_q ? shMode_q[MODE_WRITE_BIT] : shMode_q[MODE_READ_BIT];
        unusedOk    = &{1'b0, real_miso_data, real_mosi_data};
    end

    mitm_addr_matcher #(
        .ADDR_BITS (ADDR_BITS),
        .HIT_W     (HIT_W)
    ) u_matcher (
        .addr_i     (addrBits),
        .cfgAddr_i  (shAddr_q),
        .cfgMask_i  (shMask_q),
        .modeOk_i   (modeOk),
        .hitLimit_i (shLimit_q),
        .hitCount_i (hitCount_q),
        .hit_o      (ruleHit)
    );

    // Next-state and output decode; every register holds unless its phase's
    // eval (or mitm_start in IDLE) is accepted.
    always_comb begin
        state_d     = state_q;
        fakeMiso_d  = fakeMiso_q;
        fakeMosi_d  = fakeMosi_q;
        dataSize_d  = dataSize_q;
        misoSel_d   = misoSel_q;
        mosiSel_d   = mosiSel_q;
        hitCount_d  = hitCount_q;
        evalDone_d  = evalDone_q;
        mitmDone_d  = mitmDone_q;
        opIsWrite_d = opIsWrite_q;
        shMode_d    = shMode_q;
        shAddr_d    = shAddr_q;
        shMask_d    = shMask_q;
        shData_d    = shData_q;
        shLimit_d   = shLimit_q;
        case (state_q)
            ST_RESET: begin
                evalDone_d = 1'b1;
                mitmDone_d = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_IDLE: begin
                if (mitm_start) begin
                    mitmDone_d = 1'b0;
                    shMode_d   = mitmModeT'(cfg_mode);
                    shAddr_d   = cfg_addr;
                    shMask_d   = cfg_addr_mask;
                    shData_d   = cfg_data;
                    shLimit_d  = cfg_hit_limit;
                    state_d    = ST_HDR;
                end
            end
            ST_HDR: begin
                if (eval) begin
                    dataSize_d = DATA_SIZE_WIDTH'(HDR_BITS);
                    misoSel_d  = 1'b0;
                    mosiSel_d  = 1'b0;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (eval) begin
                    if (hdrBits == READ_HDR || hdrBits == WRITE_HDR) begin
                        dataSize_d  = DATA_SIZE_WIDTH'(ADDR_BITS);
                        opIsWrite_d = (hdrBits == WRITE_HDR);
                        state_d     = ST_DATA;
                    end else begin
                        mitmDone_d = 1'b1;
                        dataSize_d = '0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (eval) begin
                    dataSize_d = DATA_SIZE_WIDTH'(DATA_BITS);
                    if (ruleHit) begin
                        if (opIsWrite_q) begin
                            fakeMosi_d = fakeAligned;
                            mosiSel_d  = 1'b1;
                        end else begin
                            fakeMiso_d = fakeAligned;
                            misoSel_d  = 1'b1;
                        end
                        if (hitCount_q != '1) begin
                            hitCount_d = hitCount_q + HIT_W'(1);
                        end
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (eval) begin
                    mitmDone_d = 1'b1;
                    dataSize_d = '0;
                    misoSel_d  = 1'b0;
                    mosiSel_d  = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                evalDone_d = 1'b0;
                mitmDone_d = 1'b0;
                state_d    = ST_RESET;
            end
        endcase
    end

    // State and output registers; reset clears everything and abandons any
    // frame in flight.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= ST_RESET;
            fakeMiso_q  <= '0;
            fakeMosi_q  <= '0;
            dataSize_q  <= '0;
            misoSel_q   <= 1'b0;
            mosiSel_q   <= 1'b0;
            hitCount_q  <= '0;
            evalDone_q  <= 1'b0;
            mitmDone_q  <= 1'b0;
            opIsWrite_q <= 1'b0;
            shMode_q    <= MODE_OFF;
            shAddr_q    <= '0;
            shMask_q    <= '0;
            shData_q    <= '0;
            shLimit_q   <= '0;
        end else begin
            state_q     <= state_d;
            fakeMiso_q  <= fakeMiso_d;
            fakeMosi_q  <= fakeMosi_d;
            dataSize_q  <= dataSize_d;
            misoSel_q   <= misoSel_d;
            mosiSel_q   <= mosiSel_d;
            hitCount_q  <= hitCount_d;
            evalDone_q  <= evalDone_d;
            mitmDone_q  <= mitmDone_d;
            opIsWrite_q <= opIsWrite_d;
            shMode_q    <= shMode_d;
            shAddr_q    <= shAddr_d;
            shMask_q    <= shMask_d;
            shData_q    <= shData_d;
            shLimit_q   <= shLimit_d;
        end
    end

    assign fake_miso_data   = fakeMiso_q;
    assign fake_mosi_data   = fakeMosi_q;
    assign data_size        = dataSize_q;
    assign fake_miso_select = misoSel_q;
    assign fake_mosi_select = mosiSel_q;
    assign hit_count        = hitCount_q;
    assign eval_done        = evalDone_q;
    assign mitm_done        = mitmDone_q;

endmodule

// File: doc/mitm_rule_engine.md
Name: mitm_rule_engine

Overview:
Parametrised successor to the single-rule SPI EEPROM interceptor. Sequences the header, address and data phases of Microwire/93Cxx-style frames, and spoofs MISO (read) and/or MOSI (write) data when the frame address matches a runtime-programmable address/mask. It sits between the bus sniff/shift buffers and the fake-data write buffers, and uses the same eval/eval_done and mitm_start/mitm_done handshakes as the existing MITM logic. It adds shadowed runtime config, a mode select, a hit limit and a hit counter.

Parameters:
MAX_DATA_SIZE, 16, width of data buses; must be >= max(HDR_BITS, ADDR_BITS, DATA_BITS)
HDR_BITS, 3, start bit + opcode bits
ADDR_BITS, 9, address phase length in bits
DATA_BITS, 8, data phase length in bits
READ_HDR, 3'b110, header value identifying a read
WRITE_HDR, 3'b101, header value identifying a write
HIT_W, 8, width of hit counter and hit limit
DATA_SIZE_WIDTH, $clog2(MAX_DATA_SIZE+1), derived; not overridden

Ports:
sys_clk  in  1  system clock
rst  in  1  synchronous active-high reset
eval  in  1  1-cycle pulse: previous phase complete, real_*_data valid
mitm_start  in  1  arm for one frame
real_miso_data  in  MAX_DATA_SIZE  sniffed MISO bits, latest bit at [0]
real_mosi_data  in  MAX_DATA_SIZE  sniffed MOSI bits, latest bit at [0]
cfg_mode  in  2  0 off, 1 spoof reads, 2 spoof writes, 3 both
cfg_addr  in  ADDR_BITS  match address
cfg_addr_mask  in  ADDR_BITS  1 = bit compared
cfg_data  in  DATA_BITS  substitute data
cfg_hit_limit  in  HIT_W  max spoofs; 0 = unlimited
fake_miso_data  out  MAX_DATA_SIZE  MSB-aligned fake MISO data
fake_mosi_data  out  MAX_DATA_SIZE  MSB-aligned fake MOSI data
data_size  out  DATA_SIZE_WIDTH  bits to shift in next phase
fake_miso_select  out  1  drive fake MISO during next phase
fake_mosi_select  out  1  drive fake MOSI during next phase
hit_count  out  HIT_W  spoofs performed; saturates at all-ones
eval_done  out  1  ready level
mitm_done  out  1  frame handling complete level

Behaviour:
- Reset (rst=1 in a cycle): all outputs are 0 on the next edge, including eval_done, mitm_done and hit_count, and state = RESET. On the first cycle with rst=0, RESET -> IDLE, with eval_done=1 and mitm_done=1. Reset mid-frame abandons the frame immediately.
- IDLE: mitm_start=1 -> mitm_done<=0, shadow registers <= cfg_*, state HDR. eval is ignored. mitm_start is ignored in all other states.
- HDR: on eval -> data_size<=HDR_BITS, both selects <= 0, state ADDR.
- ADDR: on eval, hdr = real_mosi_data[HDR_BITS-1:0].
  - If hdr==READ_HDR or hdr==WRITE_HDR: data_size<=ADDR_BITS, record the op, state DATA.
  - Otherwise: mitm_done<=1, data_size<=0, state IDLE.
- DATA: on eval, addr = real_mosi_data[ADDR_BITS-1:0]. Set hit = ((addr ^ sh_addr) & sh_mask)==0, AND mode bit for the op is set (read: bit0, write: bit1), AND (sh_limit==0 OR hit_count<sh_limit).
  - data_size<=DATA_BITS.
  - If hit: the matching fake_*_data <= sh_data << (MAX_DATA_SIZE-DATA_BITS), the matching select <= 1, and hit_count increments (saturating).
  - State DONE.
- DONE: on eval -> mitm_done<=1, data_size<=0, both selects <= 0, state IDLE.
- Latency: every output update occurs on the edge that samples eval. Outputs are stable until the next accepted eval.
- Shadow config is frozen for the whole frame. cfg_* changes mid-frame take effect only at the next mitm_start.
- fake_*_data holds its last value when not selected. The unused low bits are 0.
- mask=0 matches every address. cfg_mode=0 never selects but still sequences the frame.
- Illegal state -> RESET (eval_done=0, mitm_done=0).

Decomposition:
- Package mitm_pkg: state encodings, mode encodings, default READ_HDR/WRITE_HDR constants.
- Sub-module mitm_addr_matcher (combinational masked compare plus limit check, produces hit). All sequencing stays in the top module.

Test Plan:
- Reset: rst high 2 cycles then low -> all outputs 0 during reset; eval_done=1 and mitm_done=1 one cycle after release; hit_count=0.
- Read spoof: mode=1, addr=9'h05A, mask=9'h1FF, data=8'h24; start, eval, hdr 3'b110, addr 9'h05A -> data_size 3, 9, 8; fake_miso_data=16'h2400; miso_select=1; after final eval mitm_done=1 and hit_count=1.
- Mismatch and masking: addr 9'h05B with mask 1FF -> no select, hit_count unchanged; same addr with mask 1FE -> spoofed.
- Write spoof and non-match op: mode=2, hdr 3'b101 -> fake_mosi_data=16'h2400 and mosi_select=1; hdr 3'b111 -> mitm_done=1 after ADDR eval, data_size=0.
- Hit limit: limit=2, four matching reads -> spoofed on frames 1-2 only, hit_count stays 2.
- Shadow and reset mid-frame: change cfg_data to 8'hFF after mitm_start -> frame still sends 8'h24; assert rst in DATA -> selects 0 next cycle, normal recovery.
